// File: rtl/hx8352_reader.sv
`default_nettype none
// ============================================================================
// Module      : hx8352_reader
// Description : Read-side sequencer for the HX8352 8080-style 16-bit bus.
//               Writes the index register (RS=0, WR pulse), releases the bus,
//               then issues a burst of RD strobes and captures the returned
//               words. An optional leading dummy read is discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module hx8352_reader #(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int TURN_CYC    = 2,
    parameter int RD_LOW_CYC  = 4,
    parameter int RD_HIGH_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] reg_index,
    input  logic [7:0]  word_count,
    input  logic        dummy_read,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        lcd_cs,
    output logic        lcd_rs,
    output logic        lcd_wr,
    output logic        lcd_rd,
    output logic [15:0] lcd_data_out,
    output logic        lcd_data_oe,
    input  logic [15:0] lcd_data_in
);

    // Phase counter is 8 bits wide, so each phase length must be 1..256.
    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] c_WR_LO_LAST = CNT_W'(WR_LOW_CYC  - 1);
    localparam logic [CNT_W-1:0] c_WR_HI_LAST = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] c_TURN_LAST  = CNT_W'(TURN_CYC    - 1);
    localparam logic [CNT_W-1:0] c_RD_LO_LAST = CNT_W'(RD_LOW_CYC  - 1);
    localparam logic [CNT_W-1:0] c_RD_HI_LAST = CNT_W'(RD_HIGH_CYC - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETUP     = 3'd1;
    localparam logic [2:0] S_IDX_WR_LO = 3'd2;
    localparam logic [2:0] S_IDX_WR_HI = 3'd3;
    localparam logic [2:0] S_TURN      = 3'd4;
    localparam logic [2:0] S_RD_LO     = 3'd5;
    localparam logic [2:0] S_RD_HI     = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    // RD strobes still to issue: word_count + 1 + dummy, up to 257.
    logic [8:0]       r_rd_left;
    logic             r_dummy;
    logic             r_busy;
    logic             r_done;
    logic             r_rd_valid;
    logic [15:0]      r_rd_data;
    logic             r_cs;
    logic             r_rs;
    logic             r_wr;
    logic             r_rd;
    logic             r_oe;
    logic [15:0]      r_data_out;

    // Bus sequencer: every bus pin and status flag is set on the edge that
    // enters the phase in which it must be visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rd_left  <= '0;
            r_dummy    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 16'h0000;
            r_cs       <= 1'b1;
            r_rs       <= 1'b1;
            r_wr       <= 1'b1;
            r_rd       <= 1'b1;
            r_oe       <= 1'b0;
            r_data_out <= 16'h0000;
        end else begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_rd_left  <= 9'(word_count) + 9'd1 + 9'(dummy_read);
                        r_dummy    <= dummy_read;
                        r_cs       <= 1'b0;
                        r_rs       <= 1'b0;
                        r_oe       <= 1'b1;
                        r_wr       <= 1'b1;
                        r_data_out <= reg_index;
                        r_cnt      <= '0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_wr    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDX_WR_LO;
                end
                S_IDX_WR_LO: begin
                    if (r_cnt == c_WR_LO_LAST) begin
                        r_wr    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDX_WR_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDX_WR_HI: begin
                    if (r_cnt == c_WR_HI_LAST) begin
                        // Release the bus before the panel starts driving it.
                        r_rs       <= 1'b1;
                        r_oe       <= 1'b0;
                        r_data_out <= 16'h0000;
                        r_cnt      <= '0;
                        r_state    <= S_TURN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TURN: begin
                    if (r_cnt == c_TURN_LAST) begin
                        r_rd    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RD_LO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_LO: begin
                    if (r_cnt == c_RD_LO_LAST) begin
                        // Sample on the edge that ends the low phase; the
                        // leading dummy word is dropped without a valid pulse.
                        if (!r_dummy) begin
                            r_rd_data  <= lcd_data_in;
                            r_rd_valid <= 1'b1;
                        end
                        r_dummy   <= 1'b0;
                        r_rd_left <= r_rd_left - 9'd1;
                        r_rd      <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RD_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_HI: begin
                    if (r_cnt == c_RD_HI_LAST) begin
                        r_cnt <= '0;
                        if (r_rd_left != 9'd0) begin
                            r_rd    <= 1'b0;
                            r_state <= S_RD_LO;
                        end else begin
                            r_cs    <= 1'b1;
                            r_rs    <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign done         = r_done;
    assign lcd_cs       = r_cs;
    assign lcd_rs       = r_rs;
    assign lcd_wr       = r_wr;
    assign lcd_rd       = r_rd;
    assign lcd_data_out = r_data_out;
    assign lcd_data_oe  = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_hx8352_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hx8352_reader
// Description : Self-checking bench for hx8352_reader. A panel model returns
//               words from a table on each RD fall; bus activity is counted
//               per transaction and compared with totals derived from the
//               phase lengths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hx8352_reader;

    localparam int WR_LO = 2;
    localparam int WR_HI = 2;
    localparam int TURN  = 2;
    localparam int RD_LO = 4;
    localparam int RD_HI = 3;
    localparam int FIXED = 1 + WR_LO + WR_HI + TURN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] reg_index = 16'h0000;
    logic [7:0]  word_count = 8'h00;
    logic        dummy_read = 1'b0;
    logic        busy;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        lcd_cs;
    logic        lcd_rs;
    logic        lcd_wr;
    logic        lcd_rd;
    logic [15:0] lcd_data_out;
    logic        lcd_data_oe;
    logic [15:0] lcd_data_in = 16'h0000;

    hx8352_reader #(
        .WR_LOW_CYC (WR_LO),
        .WR_HIGH_CYC(WR_HI),
        .TURN_CYC   (TURN),
        .RD_LOW_CYC (RD_LO),
        .RD_HIGH_CYC(RD_HI)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .reg_index   (reg_index),
        .word_count  (word_count),
        .dummy_read  (dummy_read),
        .busy        (busy),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .done        (done),
        .lcd_cs      (lcd_cs),
        .lcd_rs      (lcd_rs),
        .lcd_wr      (lcd_wr),
        .lcd_rd      (lcd_rd),
        .lcd_data_out(lcd_data_out),
        .lcd_data_oe (lcd_data_oe),
        .lcd_data_in (lcd_data_in)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Panel word table and the index the bench expects during the WR pulse.
    logic [15:0] panel [0:511];
    logic [15:0] exp_idx   = 16'h0000;
    int          fall_base = 0;

    // Cumulative bus statistics, written only by the monitor below.
    int cyc = 0, cs_low = 0, wr_low = 0, rd_low = 0, rd_falls = 0;
    int viol = 0, wr_bad = 0, done_cnt = 0, vt_bad = 0, glitch = 0;
    int last_fall = 0, wr_rise = 0, gap_wr_rd = -1, done_gap = -1;
    bit wr_pend = 1'b0;
    logic prev_rd = 1'b1, prev_wr = 1'b1;
    logic [15:0] prev_rd_data = 16'h0000;
    logic [15:0] got_q [$];

    // Bus monitor and panel model, sampling mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (lcd_cs === 1'b0) cs_low++;
        if (lcd_wr === 1'b0) begin
            wr_low++;
            if (lcd_data_out !== exp_idx || lcd_data_oe !== 1'b1 ||
                lcd_rs !== 1'b0 || lcd_cs !== 1'b0) wr_bad++;
        end
        if (lcd_rd === 1'b0) rd_low++;
        if (lcd_wr === 1'b0 && lcd_rd === 1'b0) viol++;
        if (lcd_data_oe === 1'b1 && lcd_rd === 1'b0) viol++;
        if (lcd_wr === 1'b1 && prev_wr === 1'b0) begin
            wr_rise = cyc;
            wr_pend = 1'b1;
        end
        if (lcd_rd === 1'b0 && prev_rd === 1'b1) begin
            if (wr_pend) begin
                gap_wr_rd = cyc - wr_rise;
                wr_pend   = 1'b0;
            end
            lcd_data_in = panel[(rd_falls - fall_base) & 511];
            rd_falls++;
            last_fall = cyc;
        end
        if (rd_valid === 1'b1) begin
            got_q.push_back(rd_data);
            if (cyc - last_fall != RD_LO) vt_bad++;
        end else if (busy === 1'b1 && rd_data !== prev_rd_data) begin
            glitch++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_gap = cyc - last_fall;
        end
        prev_rd      = lcd_rd;
        prev_wr      = lcd_wr;
        prev_rd_data = rd_data;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One complete transaction; panel[] must already hold the words to return.
    task automatic run_txn(input logic [15:0] idx, input int wc, input bit dmy, input bit spam);
        int n, b_cs, b_wr, b_rdl, b_falls, b_got, b_done, b_viol, b_wrbad, b_vt, b_gl, k;
        bit seen_done;
        n = wc + 1 + int'(dmy);
        exp_idx = idx; fall_base = rd_falls;
        b_cs = cs_low; b_wr = wr_low; b_rdl = rd_low; b_falls = rd_falls;
        b_got = got_q.size(); b_done = done_cnt; b_viol = viol;
        b_wrbad = wr_bad; b_vt = vt_bad; b_gl = glitch;
        reg_index = idx; word_count = 8'(wc); dummy_read = dmy; start = 1'b1;
        tick();
        check("busy_after_start", busy, 1);
        if (!spam) start = 1'b0;
        seen_done = 1'b0;
        k = 0;
        while (k < 5000 && !seen_done) begin
            if (spam) begin
                reg_index  = 16'($urandom);
                word_count = 8'($urandom);
                dummy_read = 1'($urandom);
            end
            tick();
            if (done === 1'b1) seen_done = 1'b1;
            k++;
        end
        check("done_seen", seen_done, 1);
        check("busy_in_done", busy, 1);
        check("cs_in_done", lcd_cs, 1);
        tick();
        check("busy_drop", busy, 0);
        start = 1'b0;
        tick();
        tick();
        check("no_restart_cs", lcd_cs, 1);
        check("cs_low_cycles", cs_low - b_cs, FIXED + n * (RD_LO + RD_HI));
        check("wr_low_cycles", wr_low - b_wr, WR_LO);
        check("rd_pulses", rd_falls - b_falls, n);
        check("rd_low_cycles", rd_low - b_rdl, n * RD_LO);
        check("valid_count", got_q.size() - b_got, wc + 1);
        for (int i = 0; i <= wc && b_got + i < got_q.size(); i++)
            check("rd_data", got_q[b_got + i], panel[int'(dmy) + i]);
        check("done_count", done_cnt - b_done, 1);
        check("wr_to_rd_gap", gap_wr_rd, WR_HI + TURN);
        check("done_gap", done_gap, RD_LO + RD_HI);
        check("wr_phase_bus", wr_bad - b_wrbad, 0);
        check("bus_overlap", viol - b_viol, 0);
        check("valid_timing", vt_bad - b_vt, 0);
        check("rd_data_hold", glitch - b_gl, 0);
    endtask

    initial begin
        int wc, k, b_got, b_done, b_falls, b_cs;
        bit dmy;

        for (int i = 0; i < 512; i++) panel[i] = 16'($urandom);

        // Reset and idle.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("idle_cs", lcd_cs, 1);
        check("idle_wr", lcd_wr, 1);
        check("idle_rd", lcd_rd, 1);
        check("idle_rs", lcd_rs, 1);
        check("idle_oe", lcd_data_oe, 0);
        check("idle_busy", busy, 0);
        check("idle_rd_data", rd_data, 16'h0000);
        check("idle_no_strobes", cs_low + wr_low + rd_low, 0);

        // Panel ID read.
        panel[0] = 16'h0052;
        run_txn(16'h0000, 0, 1'b0, 1'b0);

        // GRAM burst with dummy word.
        panel[0] = 16'hDEAD; panel[1] = 16'h1111; panel[2] = 16'h2222; panel[3] = 16'h3333;
        run_txn(16'h0022, 2, 1'b1, 1'b0);

        // start held high with changing inputs for the whole transaction.
        for (int i = 0; i < 8; i++) panel[i] = 16'($urandom);
        run_txn(16'h00A5, 3, 1'b0, 1'b1);

        // Randomized transactions.
        for (int t = 0; t < 5; t++) begin
            wc  = $urandom_range(0, 12);
            dmy = 1'($urandom);
            for (int i = 0; i < 16; i++) panel[i] = 16'($urandom);
            run_txn(16'($urandom), wc, dmy, 1'($urandom_range(0, 1)));
        end

        // Reset during the second RD low phase of a 4-word burst.
        for (int i = 0; i < 8; i++) panel[i] = 16'($urandom);
        exp_idx = 16'h0C0C; fall_base = rd_falls; b_falls = rd_falls;
        reg_index = 16'h0C0C; word_count = 8'd3; dummy_read = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (k < 500 && rd_falls - b_falls < 2) begin
            tick();
            k++;
        end
        check("second_rd_reached", rd_falls - b_falls, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_cs", lcd_cs, 1);
        check("rst_rd", lcd_rd, 1);
        check("rst_oe", lcd_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_data", rd_data, 16'h0000);
        b_got = got_q.size(); b_done = done_cnt; b_falls = rd_falls; b_cs = cs_low;
        repeat (40) tick();
        check("rst_no_valid", got_q.size() - b_got, 0);
        check("rst_no_done", done_cnt - b_done, 0);
        check("rst_no_bus", (rd_falls - b_falls) + (cs_low - b_cs), 0);
        for (int i = 0; i < 8; i++) panel[i] = 16'($urandom);
        run_txn(16'h1234, 3, 1'b0, 1'b0);

        // Maximum length burst.
        for (int i = 0; i < 512; i++) panel[i] = 16'($urandom);
        run_txn(16'h0022, 255, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
